// File: rtl/renode_pkg.sv
// Shared types for the Renode bus-peripheral side: transfer size encoding,
// bridge FSM states and the write-strobe decode result.
package renode_pkg;

  localparam int StrbWidth = 4;

  typedef enum logic [1:0] {
    Byte       = 2'd0,
    Word       = 2'd1,
    DoubleWord = 2'd2
  } valid_bits_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } bridge_state_e;

  typedef struct packed {
    logic        legal;
    valid_bits_e size;
    logic [1:0]  offset;
  } strb_decode_t;

endpackage

// File: rtl/renode_apb4_strobe_decoder.sv
// Maps an APB4 write strobe to a Renode access size and byte offset;
// only naturally aligned byte, half-word and full-word patterns are legal.
module renode_apb4_strobe_decoder
  import renode_pkg::*;
(
  input  logic [StrbWidth-1:0] pstrb,
  output strb_decode_t         decode
);

  logic [StrbWidth-1:0] onehot_hit;
  logic [1:0]           onehot_idx;

  genvar gi;
  generate
    for (gi = 0; gi < StrbWidth; gi++) begin : g_hit
      assign onehot_hit[gi] = (pstrb == StrbWidth'(1 << gi));
    end
  endgenerate

  always_comb begin
    onehot_idx = 2'd0;
    for (int i = 0; i < StrbWidth; i++) begin
      if (onehot_hit[i]) onehot_idx = 2'(i);
    end
  end

  always_comb begin
    decode = '{legal: 1'b0, size: DoubleWord, offset: 2'd0};
    if (pstrb == 4'b1111)      decode = '{legal: 1'b1, size: DoubleWord, offset: 2'd0};
    else if (pstrb == 4'b0011) decode = '{legal: 1'b1, size: Word,       offset: 2'd0};
    else if (pstrb == 4'b1100) decode = '{legal: 1'b1, size: Word,       offset: 2'd2};
    else if (|onehot_hit)      decode = '{legal: 1'b1, size: Byte,       offset: onehot_idx};
  end

endmodule

// File: rtl/renode_apb4_peripheral_bridge.sv
// APB4 completer that turns each transfer into one request/response exchange
// with the Renode side. Optional watchdog: RENODE_APB_BRIDGE_TIMEOUT_EN.
module renode_apb4_peripheral_bridge
  import renode_pkg::*;
#(
  parameter int AddressWidth  = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [AddressWidth-1:0] paddr,
  input  logic [DataWidth-1:0]    pwdata,
  input  logic [DataWidth/8-1:0]  pstrb,
  output logic                    pready,
  output logic [DataWidth-1:0]    prdata,
  output logic                    pslverr,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic                    req_write,
  output logic [AddressWidth-1:0] req_addr,
  output logic [DataWidth-1:0]    req_data,
  output logic [1:0]              req_size,
  input  logic                    rsp_valid,
  output logic                    rsp_ready,
  input  logic [DataWidth-1:0]    rsp_data,
  input  logic                    rsp_error
);

  generate
    if (DataWidth != 32) begin : g_bad_data_width
      $error("renode_apb4_peripheral_bridge: DataWidth must be 32");
    end
    if (TimeoutCycles < 2) begin : g_bad_timeout
      $error("renode_apb4_peripheral_bridge: TimeoutCycles must be >= 2");
    end
  endgenerate

  bridge_state_e state_reg;
  logic [1:0]    offset_reg;
  strb_decode_t  dec;
  logic          req_launch;

  renode_apb4_strobe_decoder u_strobe_decoder (
    .pstrb  (pstrb),
    .decode (dec)
  );

`ifdef RENODE_APB_BRIDGE_TIMEOUT_EN
  localparam int CntWidth = $clog2(TimeoutCycles + 1);
  logic [CntWidth-1:0] tmo_cnt_reg;
  logic                drop_pending_reg;
  logic                tmo_hit;
  logic                drop_hold;

  assign tmo_hit   = (tmo_cnt_reg >= CntWidth'(TimeoutCycles - 1));
  // The orphaned response must be drained before a new request may go out.
  assign drop_hold = drop_pending_reg && !(rsp_valid && rsp_ready);
  assign req_launch = !drop_hold;
`else
  assign req_launch = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      pready     <= 1'b0;
      prdata     <= '0;
      pslverr    <= 1'b0;
      req_valid  <= 1'b0;
      req_write  <= 1'b0;
      req_addr   <= '0;
      req_data   <= '0;
      req_size   <= DoubleWord;
      rsp_ready  <= 1'b0;
      offset_reg <= 2'd0;
`ifdef RENODE_APB_BRIDGE_TIMEOUT_EN
      tmo_cnt_reg      <= '0;
      drop_pending_reg <= 1'b0;
`endif
    end else begin
`ifdef RENODE_APB_BRIDGE_TIMEOUT_EN
      if (state_reg == REQ || state_reg == WAIT) tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      if (drop_pending_reg && rsp_valid && rsp_ready) begin
        drop_pending_reg <= 1'b0;
        rsp_ready        <= 1'b0;
      end
`endif
      case (state_reg)
        IDLE: begin
          if (psel && penable) begin
            if (pwrite && !dec.legal) begin
              state_reg <= ERR;
              pready    <= 1'b1;
              pslverr   <= 1'b1;
              prdata    <= '0;
            end else begin
              state_reg <= REQ;
              req_valid <= req_launch;
              req_write <= pwrite;
`ifdef RENODE_APB_BRIDGE_TIMEOUT_EN
              tmo_cnt_reg <= '0;
`endif
              if (pwrite) begin
                req_addr   <= {paddr[AddressWidth-1:2], dec.offset};
                req_data   <= pwdata >> {dec.offset, 3'b000};
                req_size   <= dec.size;
                offset_reg <= dec.offset;
              end else begin
                req_addr   <= paddr;
                req_data   <= '0;
                req_size   <= DoubleWord;
                offset_reg <= 2'd0;
              end
            end
          end
        end
        REQ: begin
          if (req_valid && req_ready) begin
            req_valid <= 1'b0;
            rsp_ready <= 1'b1;
            state_reg <= WAIT;
          end
`ifdef RENODE_APB_BRIDGE_TIMEOUT_EN
          // Never accepted, so no response will follow: no drop needed.
          else if (tmo_hit) begin
            req_valid <= 1'b0;
            pready    <= 1'b1;
            pslverr   <= 1'b1;
            prdata    <= '0;
            state_reg <= DONE;
          end
`endif
          else begin
            req_valid <= req_launch;
          end
        end
        WAIT: begin
          if (rsp_valid) begin
            rsp_ready <= 1'b0;
            pready    <= 1'b1;
            pslverr   <= rsp_error;
            prdata    <= (req_write || rsp_error) ? '0 : rsp_data << {offset_reg, 3'b000};
            state_reg <= DONE;
          end
`ifdef RENODE_APB_BRIDGE_TIMEOUT_EN
          else if (tmo_hit) begin
            drop_pending_reg <= 1'b1;
            pready           <= 1'b1;
            pslverr          <= 1'b1;
            prdata           <= '0;
            state_reg        <= DONE;
          end
`endif
        end
        DONE, ERR: begin
          pready    <= 1'b0;
          pslverr   <= 1'b0;
          prdata    <= '0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_renode_apb4_peripheral_bridge.sv
// Randomized bench for renode_apb4_peripheral_bridge against a byte-lane
// reference model; exercises the watchdog when RENODE_APB_BRIDGE_TIMEOUT_EN is set.
module tb_renode_apb4_peripheral_bridge;
  import renode_pkg::*;

`ifdef RENODE_APB_BRIDGE_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic        req_valid, req_write;
  logic        req_ready = 1'b0;
  logic [31:0] req_addr, req_data;
  logic [1:0]  req_size;
  logic        rsp_valid = 1'b0, rsp_error = 1'b0;
  logic        rsp_ready;
  logic [31:0] rsp_data = '0;

  int errors = 0;
  int checks = 0;
  int txn_id = 0;

  always #5 clk = ~clk;

  renode_apb4_peripheral_bridge #(
    .AddressWidth (32),
    .DataWidth    (32),
    .TimeoutCycles(TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .pready    (pready),
    .prdata    (prdata),
    .pslverr   (pslverr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_error (rsp_error)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (txn %0d)", tag, got, exp, txn_id);
    end
  endtask

  // Legal writes cover a naturally aligned run of 1, 2 or 4 byte lanes.
  function automatic void model(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strb, output bit legal, output logic [1:0] size,
                                output logic [31:0] eaddr, output logic [31:0] edata);
    int nb;
    int lo;
    int mask;
    if (!wr) begin
      legal = 1'b1; size = DoubleWord; eaddr = addr; edata = '0;
      return;
    end
    nb = $countones(strb);
    lo = 0;
    for (int i = 3; i >= 0; i--) if (strb[i]) lo = i;
    legal = 1'b0;
    if (nb == 1 || nb == 2 || nb == 4) begin
      mask  = ((1 << nb) - 1) << lo;
      legal = ((lo % nb) == 0) && (int'(strb) == mask);
    end
    size  = (nb == 1) ? Byte : (nb == 2) ? Word : DoubleWord;
    eaddr = {addr[31:2], 2'(lo)};
    edata = wdata >> (8 * lo);
  endfunction

  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int d, input int r,
                      input logic [31:0] rdata, input bit rerr);
    bit          legal;
    logic [1:0]  esize;
    logic [31:0] eaddr, edata, eprdata;
    int          k, rv_n, rr_n;
    bit          done, req_hs, rsp_hs;
    model(wr, addr, wdata, strb, legal, esize, eaddr, edata);
    eprdata = (!wr && !rerr) ? rdata : 32'h0;
    txn_id++;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    @(negedge clk);
    penable = 1'b1;
    k = 0; rv_n = 0; rr_n = 0; done = 1'b0; req_hs = 1'b0; rsp_hs = 1'b0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
      if (req_hs) req_ready = 1'b0;
      if (rsp_hs) begin rsp_valid = 1'b0; rsp_data = '0; rsp_error = 1'b0; end
      req_hs = 1'b0; rsp_hs = 1'b0;
      if (pready) begin
        done = 1'b1;
        check("latency", 64'(k), 64'(legal ? 3 + d + r : 1));
        check("pslverr", 64'(pslverr), 64'(legal ? rerr : 1'b1));
        check("prdata", 64'(prdata), 64'(legal ? eprdata : 32'h0));
      end
      if (req_valid) begin
        rv_n++;
        check("req_write", 64'(req_write), 64'(wr));
        check("req_addr", 64'(req_addr), 64'(eaddr));
        check("req_data", 64'(req_data), 64'(edata));
        check("req_size", 64'(req_size), 64'(esize));
        check("rsp_ready_in_req", 64'(rsp_ready), 64'(0));
        if (rv_n > d) begin req_ready = 1'b1; req_hs = 1'b1; end
      end
      if (rsp_ready && !done) begin
        if (rr_n >= r) begin
          rsp_valid = 1'b1; rsp_data = rdata; rsp_error = rerr; rsp_hs = 1'b1;
        end
        rr_n++;
      end
    end
    check("xfer_done", 64'(done), 64'(1));
    check("req_valid_cycles", 64'(rv_n), 64'(legal ? d + 1 : 0));
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
    check("pready_pulse", 64'(pready), 64'(0));
    check("prdata_idle", 64'(prdata), 64'(0));
    $display("txn %0d wr=%0b addr=0x%08h strb=%b legal=%0b req_delay=%0d rsp_delay=%0d err=%0b cycles=%0d",
             txn_id, wr, addr, strb, legal, d, r, rerr, k);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pready"}, 64'(pready), 64'(0));
    check({tag, "_prdata"}, 64'(prdata), 64'(0));
    check({tag, "_pslverr"}, 64'(pslverr), 64'(0));
    check({tag, "_req_valid"}, 64'(req_valid), 64'(0));
    check({tag, "_req_write"}, 64'(req_write), 64'(0));
    check({tag, "_req_addr"}, 64'(req_addr), 64'(0));
    check({tag, "_req_data"}, 64'(req_data), 64'(0));
    check({tag, "_req_size"}, 64'(req_size), 64'(DoubleWord));
    check({tag, "_rsp_ready"}, 64'(rsp_ready), 64'(0));
  endtask

  initial begin
    int k;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    xfer(1'b0, 32'h0000_1000, 32'h0, 4'h0, 0, 3, 32'hDEAD_BEEF, 1'b0);
    xfer(1'b1, 32'h0000_2000, 32'h00AB_0000, 4'b0100, 0, 0, 32'h1234_5678, 1'b0);
    xfer(1'b1, 32'h0000_2000, 32'h1122_3344, 4'b0110, 0, 0, 32'h0, 1'b0);
    xfer(1'b0, 32'h0000_1100, 32'h0, 4'hF, 5, 1, 32'hCAFE_F00D, 1'b1);
    xfer(1'b0, 32'h0000_1004, 32'h0, 4'h0, 0, 0, 32'h0BAD_F00D, 1'b0);

    // Reset asserted while waiting for a response.
    txn_id++;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_6000;
    @(negedge clk);
    penable = 1'b1;
    k = 0;
    while (k < 20 && !rsp_ready) begin
      @(negedge clk);
      k++;
      req_ready = req_valid;
    end
    check("rst_wait_reached", 64'(rsp_ready), 64'(1));
    req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_in_wait");
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn %0d reset asserted in WAIT after %0d cycles", txn_id, k);
    xfer(1'b0, 32'h0000_7000, 32'h0, 4'h0, 0, 0, 32'h7777_0001, 1'b0);

    for (int n = 0; n < 40; n++) begin
      xfer(1'($urandom), $urandom, $urandom, 4'($urandom), int'($urandom_range(3, 0)),
           int'($urandom_range(3, 0)), $urandom, ($urandom_range(4, 0) == 0));
    end

`ifdef RENODE_APB_BRIDGE_TIMEOUT_EN
    // Accepted request that is never answered.
    txn_id++;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_3000;
    @(negedge clk);
    penable = 1'b1;
    k = 0;
    while (k < 40 && !pready) begin
      @(negedge clk);
      k++;
      req_ready = req_valid;
    end
    check("tmo_latency", 64'(k), 64'(TMO + 1));
    check("tmo_pslverr", 64'(pslverr), 64'(1));
    check("tmo_prdata", 64'(prdata), 64'(0));
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; req_ready = 1'b0;
    check("tmo_drop_rsp_ready", 64'(rsp_ready), 64'(1));
    $display("txn %0d timeout after %0d cycles", txn_id, k);
    // Next read must hold off until the late response has been discarded.
    txn_id++;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_4000;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    check("tmo_hold_req_1", 64'(req_valid), 64'(0));
    @(negedge clk);
    check("tmo_hold_req_2", 64'(req_valid), 64'(0));
    rsp_valid = 1'b1; rsp_data = 32'h5555_AAAA;
    @(negedge clk);
    rsp_valid = 1'b0; rsp_data = '0;
    check("tmo_req_after_drop", 64'(req_valid), 64'(1));
    check("tmo_req_addr", 64'(req_addr), 64'(32'h0000_4000));
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    check("tmo_rsp_ready_wait", 64'(rsp_ready), 64'(1));
    rsp_valid = 1'b1; rsp_data = 32'h0000_BEEF;
    @(negedge clk);
    rsp_valid = 1'b0; rsp_data = '0;
    check("tmo_next_pready", 64'(pready), 64'(1));
    check("tmo_next_prdata", 64'(prdata), 64'(32'h0000_BEEF));
    check("tmo_next_pslverr", 64'(pslverr), 64'(0));
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    $display("txn %0d read after dropped response", txn_id);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
